out_uart: RTL and testbench
===========================

Name: out_uart

Overview:
- Downstream consumer of the core's output port (out_en/out_data).
- Buffers emitted bytes in a small FIFO and serialises them on a UART TX line, 8N1 by default, LSB first.
- The core has no backpressure, so the block never stalls it: it drops bytes on overflow and flags the drop.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit; minimum 2.
FIFO_DEPTH, 16, byte slots; must be a power of two, minimum 2.
FIFO_AW, $clog2(FIFO_DEPTH), derived pointer width; not overridden.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
out_en  input  1  byte-valid strobe from core; one byte per asserted cycle.
out_data  input  8  byte from core; sampled when out_en=1.
overflow_clr  input  1  synchronous clear of overflow flag.
tx  output  1  UART serial line; idles high.
busy  output  1  1 when FIFO non-empty or a frame is in progress.
fifo_full  output  1  count == FIFO_DEPTH.
fifo_count  output  FIFO_AW+1  bytes currently buffered, 0..FIFO_DEPTH.
overflow  output  1  sticky; set when a byte was dropped.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied: pointers = 0, fifo_count = 0.
  - FSM enters IDLE; baud counter and bit index = 0.
  - tx=1, busy=0, fifo_full=0, overflow=0, all immediately.
  - A frame cut off mid-transmission is abandoned, not resumed.
- Push:
  - On an edge with out_en=1 and count<FIFO_DEPTH, write out_data at the write pointer and increment it (wraps modulo FIFO_DEPTH).
  - Push acceptance uses the pre-edge count only. A pop in the same cycle does not make room for a push into a full FIFO.
- Overflow:
  - out_en=1 while full drops the byte and sets overflow on that edge.
  - overflow_clr=1 clears overflow. If clear and a new drop coincide, set wins.
- Count: simultaneous accepted push and pop leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: tx=1. On an edge where count>0, pop the head into the shift register, zero the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[0]; shift right every CLKS_PER_BIT cycles; after bit 7, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency and frame length:
  - A byte pushed into an empty FIFO at edge N is popped at edge N+1; tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles (11* with parity), plus one IDLE cycle between back-to-back frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at the bit boundary.
- tx is driven from a register; it is glitch-free and changes only at bit boundaries.
- busy = (state != IDLE) || (count != 0).
- Byte order: bytes leave in strict FIFO order; a dropped byte leaves no gap or garbage on the line.

Optional Feature:
OUT_UART_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; 8N1 frame of 10*CLKS_PER_BIT cycles.
- Ports are identical in both builds.

Test Plan:
(All tests: CLKS_PER_BIT=4, FIFO_DEPTH=4.)
- Reset then idle 50 cycles -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
- Single out_en with 0x41 at edge N -> tx low for cycles N+1..N+4, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then stop high for 4 cycles; busy drops after frame; 40 cycles total.
- Push 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles:
  - fifo_count peaks at 4; fifo_full=1; overflow sets on the first rejected push.
  - Line carries 0x01,0x02,0x03,0x04,0x05 in order; 0x06 is dropped; frames are separated by exactly one idle cycle.
  - Repeat with overflow_clr=1 at the same edge as a dropped push -> overflow stays 1.
- Full FIFO, FSM pops on the same edge as out_en=1 -> byte rejected, overflow=1, fifo_count goes 4->3.
- Assert reset_n=0 mid-DATA of 0x55 with 2 bytes queued -> tx=1 immediately, fifo_count=0, busy=0. After release, no further frames are emitted.
- With OUT_UART_PARITY_EN, send 0x07 -> parity bit 1, frame 44 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/out_uart.sv
// out_uart: buffers bytes from the core's output port in a small FIFO and
// serialises them on a UART TX line (8N1, LSB first). The core cannot be
// stalled, so bytes arriving while the FIFO is full are dropped and a sticky
// overflow flag is raised.
//
// Optional feature macro: OUT_UART_PARITY_EN -- inserts an even-parity bit
// between the data bits and the stop bit (8E1 frame). Ports are unchanged.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   out_en       byte-valid strobe from core
//   out_data     byte from core, sampled when out_en=1
//   overflow_clr synchronous clear of the overflow flag
//   tx           UART serial line, idles high
//   busy         FIFO non-empty or frame in progress
//   fifo_full    fifo_count == FIFO_DEPTH
//   fifo_count   bytes buffered, 0..FIFO_DEPTH
//   overflow     sticky, set when a byte was dropped
module out_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FIFO_AW      = $clog2(FIFO_DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             out_en,
  input  logic [7:0]       out_data,
  input  logic             overflow_clr,
  output logic             tx,
  output logic             busy,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow
);

  localparam int unsigned      CntW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0]  CntMax    = CntW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CountFull = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef OUT_UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         head;
  logic               push, pop, drop, bit_done;

  assign head     = mem_q[rd_ptr_q];
  // Acceptance looks only at the pre-edge count; a same-cycle pop does not make room.
  assign push     = out_en && (count_q != CountFull);
  assign drop     = out_en && (count_q == CountFull);
  assign bit_done = (cnt_q == CntMax);

  // Set wins over clear so a drop coinciding with a clear is never lost.
  assign ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

`ifdef OUT_UART_PARITY_EN
  logic parity_q;

  // Parity is captured at pop because the shift register is consumed during DATA.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= ^head;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef OUT_UART_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= out_data;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_full  = (count_q == CountFull);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_out_uart.sv
// Self-checking bench for out_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4). A serial
// monitor decodes frames from tx and compares them against a scoreboard of
// bytes expected to be accepted; scenario tasks check timing and flags inline.
module tb_out_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FCYC = FRAME * CPB;

  logic       clock, reset_n, out_en, overflow_clr;
  logic [7:0] out_data;
  logic       tx, busy, fifo_full, overflow;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] sb[$];
  int start_cyc[$];

  out_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .out_en      (out_en),
    .out_data    (out_data),
    .overflow_clr(overflow_clr),
    .tx          (tx),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Expected line level for slot k of a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef OUT_UART_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Serial monitor: samples mid-bit; frames touched by reset are discarded.
  initial begin : monitor
    logic       prev_tx, ok, stop_b, par_b;
    logic [7:0] val, exp_b;
    prev_tx = 1'b1;
    par_b   = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && prev_tx && !tx) begin
        start_cyc.push_back(cyc);
        ok  = 1'b1;
        val = '0;
        repeat (2) @(negedge clock);
        if (tx !== 1'b0 || !reset_n) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          val[i] = tx;
          if (!reset_n) ok = 1'b0;
        end
`ifdef OUT_UART_PARITY_EN
        repeat (CPB) @(negedge clock);
        par_b = tx;
        if (!reset_n) ok = 1'b0;
`endif
        repeat (CPB) @(negedge clock);
        stop_b = tx;
        if (!reset_n) ok = 1'b0;
        if (ok) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected_frame: got %02h want none", val);
          end else begin
            exp_b = sb.pop_front();
            if (val !== exp_b) begin
              errors++;
              $display("FAIL mon_byte: got %02h want %02h", val, exp_b);
            end
`ifdef OUT_UART_PARITY_EN
            checks++;
            if (par_b !== ^exp_b) begin
              errors++;
              $display("FAIL mon_parity: got %0b want %0b", par_b, ^exp_b);
            end
`endif
          end
          checks++;
          if (stop_b !== 1'b1) begin
            errors++;
            $display("FAIL mon_stop: got %0b want 1", stop_b);
          end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0b want 0", busy);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    out_en       = 1'b0;
    out_data     = '0;
    overflow_clr = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      checks++;
      if ({tx, busy, fifo_full, overflow, fifo_count} !== 7'b1000000) begin
        errors++;
        $display("FAIL reset_idle: got tx=%0b busy=%0b full=%0b ovf=%0b cnt=%0d want 1 0 0 0 0",
                 tx, busy, fifo_full, overflow, fifo_count);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] b);
    @(negedge clock);
    out_en   = 1'b1;
    out_data = b;
    sb.push_back(b);
    @(negedge clock);  // after push edge N
    out_en = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_push_edge: got tx=%0b busy=%0b want 1 1", tx, busy);
    end
    for (int m = 1; m <= FCYC; m++) begin
      @(negedge clock);
      checks++;
      if (tx !== exp_tx(b, (m - 1) / CPB)) begin
        errors++;
        $display("FAIL frame_tx_%02h_c%0d: got %0b want %0b", b, m, tx, exp_tx(b, (m - 1) / CPB));
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_busy_last: got %0b want 1", busy);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL frame_end: got busy=%0b tx=%0b want 0 1", busy, tx);
    end
    wait_idle(20);
  endtask

  task automatic test_overflow(input logic clr_on_drop);
    int exp_cnt[6]  = '{1, 1, 2, 3, 4, 4};
    int exp_ovf[6]  = '{0, 0, 0, 0, 0, 1};
    int exp_full[6] = '{0, 0, 0, 0, 1, 1};
    int n0;
    n0 = start_cyc.size();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clock);
      if (i > 0) begin
        checks++;
        if (fifo_count !== 3'(exp_cnt[i-1])) begin
          errors++;
          $display("FAIL ovf_count_e%0d: got %0d want %0d", i, fifo_count, exp_cnt[i-1]);
        end
        checks++;
        if (overflow !== 1'(exp_ovf[i-1])) begin
          errors++;
          $display("FAIL ovf_flag_e%0d: got %0b want %0d", i, overflow, exp_ovf[i-1]);
        end
        checks++;
        if (fifo_full !== 1'(exp_full[i-1])) begin
          errors++;
          $display("FAIL ovf_full_e%0d: got %0b want %0d", i, fifo_full, exp_full[i-1]);
        end
      end
      if (i < 6) begin
        out_en       = 1'b1;
        out_data     = 8'(i + 1);
        overflow_clr = clr_on_drop && (i == 5);
        // Sixth byte arrives while full and is the only one dropped.
        if (i < 5) sb.push_back(8'(i + 1));
      end else begin
        out_en       = 1'b0;
        overflow_clr = 1'b0;
      end
    end
    wait_idle(6 * (FCYC + 1));
    checks++;
    if (start_cyc.size() != n0 + 5) begin
      errors++;
      $display("FAIL ovf_frames: got %0d want 5", start_cyc.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (start_cyc[n0+i+1] - start_cyc[n0+i] != FCYC + 1) begin
          errors++;
          $display("FAIL ovf_gap%0d: got %0d want %0d", i,
                   start_cyc[n0+i+1] - start_cyc[n0+i], FCYC + 1);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0b want 1", overflow);
    end
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %0b want 0", overflow);
    end
  endtask

  task automatic test_pop_collision();
    @(negedge clock);
    out_en   = 1'b1;
    out_data = 8'hA0;
    sb.push_back(8'hA0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      out_data = 8'(8'hA0 + i);
      sb.push_back(8'(8'hA0 + i));
    end
    @(negedge clock);  // after edge N+4
    out_en = 1'b0;
    // Advance to just before the edge where the FSM pops its next byte.
    repeat (FCYC - 3) @(negedge clock);
    checks++;
    if (fifo_count !== 3'd4 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL coll_pre: got cnt=%0d full=%0b want 4 1", fifo_count, fifo_full);
    end
    out_en   = 1'b1;
    out_data = 8'hEE;
    @(negedge clock);
    out_en = 1'b0;
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL coll_count: got %0d want 3", fifo_count);
    end
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL coll_flags: got ovf=%0b full=%0b want 1 0", overflow, fifo_full);
    end
    wait_idle(6 * (FCYC + 1));
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n0, bad;
    @(negedge clock);
    out_en   = 1'b1;
    out_data = 8'h55;
    sb.push_back(8'h55);
    @(negedge clock);
    out_data = 8'h66;
    sb.push_back(8'h66);
    @(negedge clock);
    out_data = 8'h77;
    sb.push_back(8'h77);
    @(negedge clock);
    out_en = 1'b0;
    repeat (18) @(negedge clock);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL rmid_queued: got %0d want 2", fifo_count);
    end
    reset_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({tx, busy, fifo_full, overflow, fifo_count} !== 7'b1000000) begin
      errors++;
      $display("FAIL rmid_async: got tx=%0b busy=%0b full=%0b ovf=%0b cnt=%0d want 1 0 0 0 0",
               tx, busy, fifo_full, overflow, fifo_count);
    end
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    n0  = start_cyc.size();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rmid_quiet: got %0d active cycles want 0", bad);
    end
    checks++;
    if (start_cyc.size() != n0) begin
      errors++;
      $display("FAIL rmid_frames: got %0d want 0", start_cyc.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'h41);
`ifdef OUT_UART_PARITY_EN
    test_frame(8'h07);
    test_frame(8'h03);
`else
    test_frame(8'hA5);
`endif
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_pop_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
